micro_sequencer: RTL and testbench



---
 rtl/micro_sequencer_if.sv | 29 ++
 rtl/micro_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_micro_sequencer.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/micro_sequencer_if.sv
// Bus between the micro-sequencer, the control store and the datapath
// control bus. The sequencer drives the micro-address and control outputs;
// the control store and datapath drive the microword, opcode, flags and
// memory acknowledge.
interface micro_sequencer_if #(
  parameter int UA_W = 6
);
  logic [25:0]     uinstr;
  logic [3:0]      in_op;
  logic            SF;
  logic            ZF;
  logic            mem_ack;
  logic [UA_W-1:0] ua;
  logic [16:0]     ctrl;
  logic            mem_req;
  logic            halted;
  logic            err;
  logic            busy;

  modport master (
    input  uinstr, in_op, SF, ZF, mem_ack,
    output ua, ctrl, mem_req, halted, err, busy
  );

  modport slave (
    output uinstr, in_op, SF, ZF, mem_ack,
    input  ua, ctrl, mem_req, halted, err, busy
  );
endinterface

// File: rtl/micro_sequencer.sv
// Micro-program sequencer: owns the micro-PC, addresses the control store,
// latches the control field of each microword and stalls on memory
// micro-ops with a bounded wait.
// Optional feature: define MICRO_SEQUENCER_SSTEP_EN to add the sstep/step
// single-step ports; with it undefined RUN executes one microword per cycle.
module micro_sequencer #(
  parameter int              UA_W     = 6,
  parameter logic [UA_W-1:0] RESET_UA = 6'd1,
  parameter int              TO_CYC   = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
`ifdef MICRO_SEQUENCER_SSTEP_EN
  input  logic sstep,
  input  logic step,
`endif
  micro_sequencer_if.master bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_HALT = 2'd3;

  // Last wait-cycle count before the timeout fires.
  localparam logic [7:0] TO_LAST = 8'(TO_CYC - 1);

  logic [1:0]      state, state_n;
  logic [UA_W-1:0] ua_reg, ua_n;
  logic [16:0]     ctrl_reg, ctrl_n;
  logic            err_reg, err_n;
  logic [7:0]      cnt, cnt_n;
  logic            mem_req_reg, halted_reg, busy_reg;
  logic            exec;
  logic            mreq, halt;
  logic [UA_W-1:0] target;

  // Next micro-address from the test field, branch conditions and next field.
  function automatic logic [UA_W-1:0] next_addr(
    input logic [2:0] test,
    input logic [5:0] nxt,
    input logic [3:0] op,
    input logic       sf,
    input logic       zf
  );
    logic [UA_W-1:0] nf;
    nf = UA_W'(nxt);
    case (test)
      3'b100: begin
        case (op)
          4'b0010: next_addr = UA_W'(6'd3);
          4'b1011: next_addr = UA_W'(6'd4);
          4'b0101: next_addr = UA_W'(6'd8);
          4'b0100: next_addr = UA_W'(6'd9);
          4'b0111: next_addr = UA_W'(6'd10);
          4'b1000: next_addr = UA_W'(6'd12);
          4'b0110: next_addr = UA_W'(6'd14);
          4'b1110: next_addr = UA_W'(6'd15);
          4'b1111: next_addr = UA_W'(6'd16);
          4'b1001: next_addr = UA_W'(6'd18);
          default: next_addr = nf;
        endcase
      end
      3'b010:  next_addr = sf ? UA_W'(6'd11) : nf;
      3'b001:  next_addr = zf ? nf : UA_W'(6'd13);
      default: next_addr = nf;
    endcase
  endfunction

`ifdef MICRO_SEQUENCER_SSTEP_EN
  assign exec = !sstep || step;
`else
  assign exec = 1'b1;
`endif

  assign mreq   = bus.uinstr[25];
  assign halt   = bus.uinstr[24];
  assign target = next_addr(bus.uinstr[8:6], bus.uinstr[5:0], bus.in_op, bus.SF, bus.ZF);

  // Next-state, micro-address, control field, error flag and wait counter.
  always_comb begin
    state_n = state;
    ua_n    = ua_reg;
    ctrl_n  = ctrl_reg;
    err_n   = err_reg;
    cnt_n   = cnt;
    case (state)
      S_IDLE: begin
        ctrl_n = 17'd0;
        if (run) begin
          state_n = S_RUN;
        end else begin
          state_n = S_IDLE;
        end
      end
      S_RUN: begin
        if (!exec) begin
          state_n = S_RUN;
        end else if (mreq) begin
          state_n = S_WAIT;
          ctrl_n  = bus.uinstr[25:9];
          cnt_n   = 8'd0;
        end else if (halt) begin
          state_n = S_HALT;
          ctrl_n  = 17'd0;
        end else if (!run) begin
          // The current microword completes, then the sequencer parks.
          state_n = S_IDLE;
          ua_n    = target;
          ctrl_n  = 17'd0;
        end else begin
          ua_n   = target;
          ctrl_n = bus.uinstr[25:9];
        end
      end
      S_WAIT: begin
        if (bus.mem_ack) begin
          cnt_n = 8'd0;
          ua_n  = target;
          if (halt) begin
            state_n = S_HALT;
            ctrl_n  = 17'd0;
          end else begin
            state_n = S_RUN;
          end
        end else if (cnt == TO_LAST) begin
          cnt_n   = 8'd0;
          err_n   = 1'b1;
          state_n = S_HALT;
          ctrl_n  = 17'd0;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      S_HALT: begin
        ctrl_n = 17'd0;
        if (!run) begin
          state_n = S_IDLE;
          ua_n    = RESET_UA;
          err_n   = 1'b0;
        end else begin
          state_n = S_HALT;
        end
      end
      default: begin
        state_n = S_IDLE;
        ctrl_n  = 17'd0;
      end
    endcase
  end

  // State and registered outputs; status flags follow the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      ua_reg      <= RESET_UA;
      ctrl_reg    <= 17'd0;
      err_reg     <= 1'b0;
      cnt         <= 8'd0;
      mem_req_reg <= 1'b0;
      halted_reg  <= 1'b0;
      busy_reg    <= 1'b0;
    end else begin
      state       <= state_n;
      ua_reg      <= ua_n;
      ctrl_reg    <= ctrl_n;
      err_reg     <= err_n;
      cnt         <= cnt_n;
      mem_req_reg <= (state_n == S_WAIT);
      halted_reg  <= (state_n == S_HALT);
      busy_reg    <= (state_n == S_RUN) || (state_n == S_WAIT);
    end
  end

  assign bus.ua      = ua_reg;
  assign bus.ctrl    = ctrl_reg;
  assign bus.mem_req = mem_req_reg;
  assign bus.halted  = halted_reg;
  assign bus.err     = err_reg;
  assign bus.busy    = busy_reg;

endmodule

// File: tb/tb_micro_sequencer.sv
// Self-checking bench for micro_sequencer: a behavioural model tracks the
// expected outputs every cycle, and directed vectors pin key values.
module tb_micro_sequencer;

  logic clk;
  logic rst_n;
  logic run;
`ifdef MICRO_SEQUENCER_SSTEP_EN
  logic sstep;
  logic step;
`endif

  micro_sequencer_if #(.UA_W(6)) bus ();

  micro_sequencer #(.UA_W(6), .RESET_UA(6'd1), .TO_CYC(255)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (run),
`ifdef MICRO_SEQUENCER_SSTEP_EN
    .sstep (sstep),
    .step  (step),
`endif
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model: mode 0 idle, 1 run, 2 waiting on memory, 3 halted.
  int          m_mode;
  logic [5:0]  m_ua;
  logic [16:0] m_ctrl;
  logic        m_err;
  int          m_waited;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [5:0] dispatch(input logic [3:0] op, input logic [5:0] nf);
    case (op)
      4'b0010: return 6'd3;
      4'b1011: return 6'd4;
      4'b0101: return 6'd8;
      4'b0100: return 6'd9;
      4'b0111: return 6'd10;
      4'b1000: return 6'd12;
      4'b0110: return 6'd14;
      4'b1110: return 6'd15;
      4'b1111: return 6'd16;
      4'b1001: return 6'd18;
      default: return nf;
    endcase
  endfunction

  function automatic logic [5:0] target(input logic [25:0] w, input logic [3:0] op,
                                        input logic s, input logic z);
    if (w[8:6] == 3'b100) return dispatch(op, w[5:0]);
    if (w[8:6] == 3'b010) return s ? 6'd11 : w[5:0];
    if (w[8:6] == 3'b001) return z ? w[5:0] : 6'd13;
    return w[5:0];
  endfunction

  task automatic model_step();
    logic [5:0] t;
    t = target(bus.uinstr, bus.in_op, bus.SF, bus.ZF);
    if (!rst_n) begin
      m_mode = 0; m_ua = 6'd1; m_ctrl = 17'd0; m_err = 1'b0; m_waited = 0;
    end else if (m_mode == 0) begin
      m_ctrl = 17'd0;
      if (run) m_mode = 1;
    end else if (m_mode == 1) begin
      if (bus.uinstr[25]) begin
        m_mode = 2; m_ctrl = bus.uinstr[25:9]; m_waited = 0;
      end else if (bus.uinstr[24]) begin
        m_mode = 3; m_ctrl = 17'd0;
      end else begin
        m_ua = t;
        m_ctrl = run ? bus.uinstr[25:9] : 17'd0;
        m_mode = run ? 1 : 0;
      end
    end else if (m_mode == 2) begin
      m_waited++;
      if (bus.mem_ack) begin
        m_ua = t;
        if (bus.uinstr[24]) begin m_mode = 3; m_ctrl = 17'd0; end
        else m_mode = 1;
      end else if (m_waited == 255) begin
        m_err = 1'b1; m_mode = 3; m_ctrl = 17'd0;
      end
    end else begin
      m_ctrl = 17'd0;
      if (!run) begin m_mode = 0; m_ua = 6'd1; m_err = 1'b0; end
    end
  endtask

  task automatic compare_all();
    chk("ua", 32'(bus.ua), 32'(m_ua));
    chk("ctrl", 32'(bus.ctrl), 32'(m_ctrl));
    chk("mem_req", 32'(bus.mem_req), 32'(m_mode == 2));
    chk("halted", 32'(bus.halted), 32'(m_mode == 3));
    chk("err", 32'(bus.err), 32'(m_err));
    chk("busy", 32'(bus.busy), 32'(m_mode == 1 || m_mode == 2));
  endtask

  // One clock: advance the model at the edge, compare at the falling edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  function automatic logic [25:0] word(input logic mreq, input logic hlt,
                                       input logic [14:0] f, input logic [2:0] tst,
                                       input logic [5:0] nxt);
    return {mreq, hlt, f, tst, nxt};
  endfunction

  int cnt;

  initial begin
    rst_n = 1'b0; run = 1'b0;
`ifdef MICRO_SEQUENCER_SSTEP_EN
    sstep = 1'b0; step = 1'b0;
`endif
    bus.uinstr = 26'd0; bus.in_op = 4'd0; bus.SF = 1'b0; bus.ZF = 1'b0; bus.mem_ack = 1'b0;
    tick(); tick();
    chk("reset_ua", 32'(bus.ua), 32'd1);
    chk("reset_busy", 32'(bus.busy), 32'd0);

    // 1: P1 dispatch
    rst_n = 1'b1; run = 1'b1;
    bus.uinstr = word(1'b0, 1'b0, 15'h1234, 3'b100, 6'd30); bus.in_op = 4'b0101;
    tick();
    chk("t1_first_ua", 32'(bus.ua), 32'd1);
    chk("t1_busy", 32'(bus.busy), 32'd1);
    tick();
    chk("t1_ua_dispatch", 32'(bus.ua), 32'd8);
    chk("t1_ctrl", 32'(bus.ctrl), 32'h1234);

    // 2: SF / ZF branches and fall-through encodings
    bus.uinstr = word(1'b0, 1'b0, 15'h0055, 3'b010, 6'd20); bus.SF = 1'b1;
    tick(); chk("t2_sf1", 32'(bus.ua), 32'd11);
    bus.SF = 1'b0;
    tick(); chk("t2_sf0", 32'(bus.ua), 32'd20);
    bus.uinstr = word(1'b0, 1'b0, 15'h0066, 3'b001, 6'd20); bus.ZF = 1'b0;
    tick(); chk("t2_zf0", 32'(bus.ua), 32'd13);
    bus.ZF = 1'b1;
    tick(); chk("t2_zf1", 32'(bus.ua), 32'd20);
    bus.uinstr = word(1'b0, 1'b0, 15'h0001, 3'b000, 6'd7);
    tick(); chk("t2_seq", 32'(bus.ua), 32'd7);
    bus.uinstr = word(1'b0, 1'b0, 15'h0002, 3'b110, 6'd21); bus.SF = 1'b1;
    tick(); chk("t2_not_onehot", 32'(bus.ua), 32'd21);
    bus.uinstr = word(1'b0, 1'b0, 15'h0003, 3'b100, 6'd63); bus.in_op = 4'b0000;
    tick(); chk("t2_p1_other", 32'(bus.ua), 32'd63);
    bus.in_op = 4'b1111;
    tick(); chk("t2_p1_1111", 32'(bus.ua), 32'd16);
    for (int op = 0; op < 16; op++) begin
      bus.in_op = 4'(op);
      tick();
    end
    // mem_ack outside a memory wait has no effect
    bus.mem_ack = 1'b1; bus.uinstr = word(1'b0, 1'b0, 15'h0004, 3'b000, 6'd2);
    tick(); bus.mem_ack = 1'b0;
    chk("t2_stray_ack", 32'(bus.mem_req), 32'd0);

    // 3: memory wait acknowledged on the 3rd wait cycle
    bus.uinstr = word(1'b1, 1'b0, 15'h0777, 3'b000, 6'd5);
    cnt = 0;
    tick(); if (bus.mem_req) cnt++;
    tick(); if (bus.mem_req) cnt++;
    tick(); if (bus.mem_req) cnt++;
    chk("t3_ua_held", 32'(bus.ua), 32'd2);
    bus.mem_ack = 1'b1;
    tick(); if (bus.mem_req) cnt++;
    bus.mem_ack = 1'b0; bus.uinstr = word(1'b0, 1'b0, 15'h0008, 3'b000, 6'd6);
    chk("t3_req_cycles", 32'(cnt), 32'd3);
    chk("t3_ua_after", 32'(bus.ua), 32'd5);
    chk("t3_busy", 32'(bus.busy), 32'd1);
    tick();

    // 4: memory timeout
    bus.uinstr = word(1'b1, 1'b0, 15'h0009, 3'b000, 6'd5);
    cnt = 0;
    tick();
    while (bus.mem_req && cnt < 400) begin
      cnt++;
      tick();
    end
    chk("t4_req_cycles", 32'(cnt), 32'd255);
    chk("t4_err", 32'(bus.err), 32'd1);
    chk("t4_halted", 32'(bus.halted), 32'd1);
    run = 1'b0;
    tick();
    chk("t4_err_clr", 32'(bus.err), 32'd0);
    chk("t4_halted_clr", 32'(bus.halted), 32'd0);
    chk("t4_ua", 32'(bus.ua), 32'd1);

    // 5: HALT microword and restart
    run = 1'b1; bus.uinstr = word(1'b0, 1'b0, 15'h000A, 3'b000, 6'd2);
    tick(); tick();
    bus.uinstr = word(1'b0, 1'b1, 15'h7FFF, 3'b000, 6'd9);
    tick();
    chk("t5_halted", 32'(bus.halted), 32'd1);
    chk("t5_ctrl", 32'(bus.ctrl), 32'd0);
    chk("t5_ua_held", 32'(bus.ua), 32'd2);
    run = 1'b0;
    tick();
    chk("t5_idle_ua", 32'(bus.ua), 32'd1);
    run = 1'b1; bus.uinstr = word(1'b0, 1'b0, 15'h000B, 3'b000, 6'd4);
    tick();
    chk("t5_restart_ua", 32'(bus.ua), 32'd1);
    tick();

    // 6: reset during a memory wait
    bus.uinstr = word(1'b1, 1'b0, 15'h000C, 3'b000, 6'd5);
    tick(); tick();
    chk("t6_req_before", 32'(bus.mem_req), 32'd1);
    rst_n = 1'b0;
    tick();
    chk("t6_req", 32'(bus.mem_req), 32'd0);
    chk("t6_ua", 32'(bus.ua), 32'd1);
    chk("t6_busy", 32'(bus.busy), 32'd0);
    chk("t6_ctrl", 32'(bus.ctrl), 32'd0);
    rst_n = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
